// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with a command stage (S1) and a response stage (S2).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_adr,
  input  logic [DATA_W-1:0] req0_dat_w,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_adr,
  input  logic [DATA_W-1:0] req1_dat_w,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_dat,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_dat,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_dat_w,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dat_r
);

  logic              s1Valid_q, s1Valid_d;
  logic              s1Owner_q, s1Owner_d;
  logic              s1We_q, s1We_d;
  logic [ADDR_W-1:0] s1Adr_q, s1Adr_d;
  logic [DATA_W-1:0] s1Dat_q, s1Dat_d;
  logic              s2Valid_q, s2Valid_d;
  logic              s2Owner_q, s2Owner_d;
  logic              s2We_q, s2We_d;
  logic              prefer0;
  logic              accept;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastGrant_q, lastGrant_d;

  // lastGrant_q resets to 1 so requester 0 wins the first contended cycle
  assign prefer0     = lastGrant_q;
  assign lastGrant_d = accept ? req1_ready : lastGrant_q;

  always_ff @(posedge clk) begin
    if (rst) lastGrant_q <= 1'b1;
    else     lastGrant_q <= lastGrant_d;
  end
`else
  assign prefer0 = 1'b1;
`endif

  always_comb begin
    req0_ready = !rst && req0_valid && (!req1_valid || prefer0);
    req1_ready = !rst && req1_valid && (!req0_valid || !prefer0);
    accept     = req0_ready || req1_ready;
    s1Valid_d  = accept;
    s1Owner_d  = req1_ready;
    s1We_d     = req1_ready ? req1_we    : req0_we;
    s1Adr_d    = req1_ready ? req1_adr   : req0_adr;
    s1Dat_d    = req1_ready ? req1_dat_w : req0_dat_w;
    s2Valid_d  = s1Valid_q;
    s2Owner_d  = s1Owner_q;
    s2We_d     = s1We_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Owner_q <= 1'b0;
      s1We_q    <= 1'b0;
      s1Adr_q   <= '0;
      s1Dat_q   <= '0;
      s2Valid_q <= 1'b0;
      s2Owner_q <= 1'b0;
      s2We_q    <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Owner_q <= s1Owner_d;
      s1We_q    <= s1We_d;
      s1Adr_q   <= s1Adr_d;
      s1Dat_q   <= s1Dat_d;
      s2Valid_q <= s2Valid_d;
      s2Owner_q <= s2Owner_d;
      s2We_q    <= s2We_d;
    end
  end

  // Outputs are gated by rst as well, so an entry caught by reset never writes or responds
  always_comb begin
    mem_we     = 1'b0;
    mem_adr    = '0;
    mem_dat_w  = '0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_dat   = '0;
    rsp1_dat   = '0;
    if (!rst && s1Valid_q) begin
      mem_we    = s1We_q;
      mem_adr   = s1Adr_q;
      mem_dat_w = s1Dat_q;
    end
    if (!rst && s2Valid_q) begin
      rsp0_valid = !s2Owner_q;
      rsp1_valid = s2Owner_q;
      if (!s2We_q) begin
        if (s2Owner_q) rsp1_dat = mem_dat_r;
        else           rsp0_dat = mem_dat_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-read memory model.
// Inputs are driven on the falling edge and outputs checked 1ns later.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_we, req0_ready;
  logic [3:0] req0_adr;
  logic [7:0] req0_dat_w;
  logic       req1_valid, req1_we, req1_ready;
  logic [3:0] req1_adr;
  logic [7:0] req1_dat_w;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_dat, rsp1_dat;
  logic [3:0] mem_adr;
  logic [7:0] mem_dat_w;
  logic       mem_we;
  logic [7:0] mem_dat_r;

  int checks = 0;
  int failures = 0;

  logic [7:0] memArr [16];
  logic [3:0] rdAdr_q;
  logic       memInit;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_adr(req0_adr),
    .req0_dat_w(req0_dat_w), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_adr(req1_adr),
    .req1_dat_w(req1_dat_w), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_dat(rsp0_dat),
    .rsp1_valid(rsp1_valid), .rsp1_dat(rsp1_dat),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we),
    .mem_dat_r(mem_dat_r)
  );

  // Memory preloads address i with i*8'h11; read address is registered
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) memArr[i] <= 8'(i * 17);
    end else if (mem_we) begin
      memArr[mem_adr] <= mem_dat_w;
    end
    rdAdr_q <= mem_adr;
  end
  assign mem_dat_r = memArr[rdAdr_q];

  task automatic idleInputs();
    req0_valid = 0; req0_we = 0; req0_adr = 0; req0_dat_w = 0;
    req1_valid = 0; req1_we = 0; req1_adr = 0; req1_dat_w = 0;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic drain();
    idleInputs();
    repeat (3) nextCycle();
  endtask

  task automatic test_reset();
    rst = 1; memInit = 1;
    idleInputs();
    req0_valid = 1; req1_valid = 1;
    nextCycle();
    memInit = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++;
    if ({mem_we, mem_adr, mem_dat_w} !== 13'h0) begin
      failures++; $display("[TB] FAIL reset_mem: got we=%b adr=%h dat=%h expected zeros", mem_we, mem_adr, mem_dat_w);
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_dat, rsp1_dat} !== 18'h0) begin
      failures++; $display("[TB] FAIL reset_rsp: got v0=%b v1=%b d0=%h d1=%h expected zeros", rsp0_valid, rsp1_valid, rsp0_dat, rsp1_dat);
    end
    nextCycle();
    rst = 0;
    idleInputs();
  endtask

  task automatic test_back_to_back();
    logic       expValid;
    logic [7:0] expData;
    drain();
    for (int k = 0; k < 11; k++) begin
      if (k > 0) nextCycle();
      idleInputs();
      if (k < 8) begin
        req1_valid = 1; req1_we = 0; req1_adr = k[3:0];
      end
      #1;
      if (k < 8) begin
        checks++;
        if (req1_ready !== 1'b1) begin
          failures++; $display("[TB] FAIL b2b_ready cycle %0d: got %b expected 1", k, req1_ready);
        end
      end
      expValid = (k >= 2) && (k < 10);
      checks++;
      if (rsp1_valid !== expValid || rsp0_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL b2b_valid cycle %0d: got v1=%b v0=%b expected v1=%b v0=0", k, rsp1_valid, rsp0_valid, expValid);
      end
      if (expValid) begin
        expData = 8'((k - 2) * 17);
        checks++;
        if (rsp1_dat !== expData) begin
          failures++; $display("[TB] FAIL b2b_data cycle %0d: got %h expected %h", k, rsp1_dat, expData);
        end
      end
    end
  endtask

  task automatic test_raw(input logic [3:0] adr, input logic [7:0] dat);
    drain();
    req0_valid = 1; req0_we = 1; req0_adr = adr; req0_dat_w = dat;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL raw_wr_ready: got %b expected 1", req0_ready);
    end
    nextCycle();
    idleInputs();
    req1_valid = 1; req1_we = 0; req1_adr = adr;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || mem_we !== 1'b1 || mem_adr !== adr) begin
      failures++; $display("[TB] FAIL raw_cycle1: got ready1=%b we=%b adr=%h expected 1 1 %h", req1_ready, mem_we, mem_adr, adr);
    end
    nextCycle();
    idleInputs();
    nextCycle();
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_dat !== dat || rsp0_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL raw_rsp: got v1=%b d1=%h v0=%b expected 1 %h 0", rsp1_valid, rsp1_dat, rsp0_valid, dat);
    end
  endtask

  task automatic test_write_rsp();
    drain();
    req0_valid = 1; req0_we = 1; req0_adr = 4'h3; req0_dat_w = 8'hA5;
    nextCycle();
    idleInputs();
    #1;
    checks++;
    if (mem_we !== 1'b1 || mem_adr !== 4'h3 || mem_dat_w !== 8'hA5) begin
      failures++; $display("[TB] FAIL wr_mem: got we=%b adr=%h dat=%h expected 1 3 a5", mem_we, mem_adr, mem_dat_w);
    end
    nextCycle();
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_dat !== 8'h00 || rsp1_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL wr_rsp: got v0=%b d0=%h v1=%b expected 1 00 0", rsp0_valid, rsp0_dat, rsp1_valid);
    end
    checks++;
    if ({mem_we, mem_adr, mem_dat_w} !== 13'h0) begin
      failures++; $display("[TB] FAIL wr_s1_empty: got we=%b adr=%h dat=%h expected zeros", mem_we, mem_adr, mem_dat_w);
    end
    nextCycle();
    #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL wr_rsp_once: got %b expected 0", rsp0_valid);
    end
  endtask

  task automatic test_arbitration();
    logic [1:0] expGrant [4];
`ifdef ARB_ROUND_ROBIN_EN
    expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    expGrant = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    drain();
    rst = 1;
    nextCycle();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      req0_valid = 1; req0_we = 0; req0_adr = 4'h1;
      req1_valid = 1; req1_we = 0; req1_adr = 4'h2;
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== expGrant[k]) begin
        failures++; $display("[TB] FAIL arb_grant cycle %0d: got {r1,r0}=%b expected %b", k, {req1_ready, req0_ready}, expGrant[k]);
      end
      nextCycle();
    end
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rsp0_valid === 1'b1 && rsp1_valid === 1'b1) begin
        failures++; $display("[TB] FAIL arb_rsp_exclusive cycle %0d: got both valid expected one", k);
      end
      nextCycle();
    end
  endtask

  task automatic test_reset_drop();
    drain();
    req0_valid = 1; req0_we = 1; req0_adr = 4'h7; req0_dat_w = 8'h5A;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL drop_accept: got %b expected 1", req0_ready);
    end
    nextCycle();
    idleInputs();
    rst = 1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      failures++; $display("[TB] FAIL drop_mem_we: got %b expected 0", mem_we);
    end
    nextCycle();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (mem_we !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL drop_quiet cycle %0d: got we=%b v0=%b v1=%b expected 0 0 0", k, mem_we, rsp0_valid, rsp1_valid);
      end
      nextCycle();
    end
    req0_valid = 1; req0_we = 0; req0_adr = 4'h7;
    nextCycle();
    idleInputs();
    nextCycle();
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_dat !== 8'h77) begin
      failures++; $display("[TB] FAIL drop_readback: got v0=%b d0=%h expected 1 77", rsp0_valid, rsp0_dat);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw(4'h3, 8'hA5);
    test_raw(4'h3, 8'h3C);
    test_write_rsp();
    test_arbitration();
    test_reset_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have, per requester n in {0,1}, ports reqn_valid (input, 1), reqn_we (input, 1), reqn_adr (input, ADDR_W) and reqn_dat_w (input, DATA_W); these carry the request strobe, write flag, address and write data.
REQ-006 SHALL have, per requester n, port reqn_ready  output  1  request accepted this cycle.
REQ-007 SHALL have, per requester n, port rspn_valid  output  1  response strobe, and port rspn_dat  output  DATA_W  response data.
REQ-008 SHALL have ports mem_adr (output, ADDR_W), mem_dat_w (output, DATA_W) and mem_we (output, 1) to the memory.
REQ-009 SHALL have port mem_dat_r  input  DATA_W  memory read data, valid one cycle after mem_adr is presented (registered read address).

Function
REQ-010 SHALL accept at most one request per cycle; a request is accepted when reqn_valid=1 and reqn_ready=1.
REQ-011 SHALL compute reqn_ready combinationally from the current valids and arbitration state; reqn_ready=0 whenever reqn_valid=0.
REQ-012 SHALL grant the sole valid requester when only one is valid.
REQ-013 SHALL, with both valid, grant the requester not granted last (round-robin); last_grant updates only on an accept.
REQ-014 SHALL register the accepted request into a command stage (S1); in the cycle after acceptance it drives mem_adr, mem_dat_w, and mem_we=reqn_we.
REQ-015 SHALL drive mem_we=0, mem_adr=0, mem_dat_w=0 whenever S1 is empty.
REQ-016 SHALL register the owner and type of each S1 entry into a response stage (S2), asserting rspn_valid for exactly one cycle, two cycles after acceptance, for both reads and writes.
REQ-017 SHALL set rspn_dat=mem_dat_r for a read response and all-zeros for a write response; rspn_dat=0 when rspn_valid=0.
REQ-018 SHALL sustain back-to-back accepts (one per cycle) with no bubbles; no response backpressure exists.
REQ-019 SHALL guarantee read-after-write ordering: a read accepted the cycle after a write to the same address returns the new data.
REQ-020 SHALL never assert rsp0_valid and rsp1_valid in the same cycle.

Reset
REQ-021 SHALL, while rst=1, hold reqn_ready=0, rspn_valid=0, rspn_dat=0, mem_we=0, mem_adr=0, mem_dat_w=0.
REQ-022 SHALL, on reset, clear S1 and S2; in-flight requests are dropped with no response and no memory write.
REQ-023 SHALL reset last_grant to requester 1, so requester 0 wins the first contended cycle.
REQ-024 SHALL leave memory contents untouched by reset.

Configuration
REQ-025 SHALL support macro ARB_ROUND_ROBIN_EN: when defined, arbitration per REQ-013; when undefined, fixed priority with requester 0 always winning contention, and last_grant not implemented.

Verification
REQ-026 SHALL cover: req0 write adr=4'h3 dat=8'hA5 at cycle 0 -> mem_we=1, mem_adr=3 at cycle 1; rsp0_valid=1, rsp0_dat=8'h00 at cycle 2.
REQ-027 SHALL cover: req0 write 4'h3=8'hA5 at cycle 0, req1 read 4'h3 at cycle 1 -> rsp1_valid=1, rsp1_dat=8'hA5 at cycle 3.
REQ-028 SHALL cover: both valid for 4 cycles after reset, with ARB_ROUND_ROBIN_EN defined -> grants 0,1,0,1; with it undefined -> grants 0,0,0,0.
REQ-029 SHALL cover: rst asserted in the cycle after a write accept to 4'h7=8'h5A -> no mem_we pulse and no rsp; a later read of 4'h7 returns the prior contents.
REQ-030 SHALL cover: 8 back-to-back reads from req1, addresses 0..7 -> rsp1_valid high for 8 consecutive cycles starting 2 cycles after the first accept, with data in address order.
